mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage initiator for the word-wide data memory; the requesting end of the data-memory interface.
- Accepts one load/store request per handshake from the pipeline.
- Performs byte/halfword extraction with sign/zero extension, and sub-word stores by read-modify-write.
- Returns a registered response; deasserts req_ready while a read-modify-write is in flight so the pipeline stalls.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words behind the port; addresses at or above MEM_WORDS*4 are errors.
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  pipeline request present.
- req_ready  out  1  unit can accept this cycle.
- req_op  in  4  opcode[3:0]: bit3 = store; LB 0000, LH 0001, LW 0011, LBU 0100, LHU 0101, SB 1000, SH 1001, SW 1011.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle pulse, request complete.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range, or undefined op; valid with resp_valid.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  word-aligned byte address to memory, bits[1:0] = 0.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  combinational read of mem_addr.

Behaviour:
- Reset (synchronous, active-high) values:
  - state = IDLE; req_ready = 1; resp_valid = 0; resp_rdata = 0; resp_err = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0.
- Endianness: little-endian. Byte lane = addr[1:0]; lane 0 = bits 7:0. Halfword lane = addr[1]; lane 0 = bits 15:0.
- Accept when req_valid && req_ready.
- Errors, checked at accept:
  - LH/LHU/SH with addr[0] = 1.
  - LW/SW with addr[1:0] != 0.
  - addr >= MEM_WORDS*4.
  - undefined op.
  - Error response: no memory access (mem_we = 0); resp_valid = 1 and resp_err = 1 next cycle; resp_rdata = 0.
- FSM states:
  - IDLE: req_ready = 1.
  - RMW: req_ready = 0.
- Loads (IDLE, accepted at cycle N):
  - mem_addr = {addr[31:2], 2'b00} combinationally in N.
  - Lane extracted and extended; registered at end of N.
  - resp_valid in N+1. Latency 1; back-to-back loads at 1 per cycle.
- SW (accepted at N): mem_we = 1, mem_wdata = req_wdata in N; resp_valid in N+1.
- SB/SH (accepted at N):
  - Cycle N: read the word; register mem_rdata merged with the req_wdata lane into merge_q; register the word address; go to RMW.
  - Cycle N+1 (RMW): mem_we = 1, mem_wdata = merge_q; req_ready = 0; return to IDLE.
  - resp_valid in N+2. A request held on req_valid during RMW is accepted at N+2.
- mem_we is asserted only in the SW accept cycle and in the RMW cycle; never on an error.
- resp_valid is a single-cycle pulse per accepted request. It never asserts without a prior accept.
- Reset during RMW: state returns to IDLE, no write issued, no response produced.
- req_valid low: no memory write; mem_addr may follow req_addr (don't-care).

Decomposition:
- Package mem_access_pkg:
  - mem_op_e enum with the eight opcodes;
  - is_store(), access_size() helpers;
  - SIZE_B/SIZE_H/SIZE_W constants.
- Sub-module lane_align: combinational.
  - Load path: extract plus sign/zero extension.
  - Store path: merge of word, data, size and lane.
  - Shared by load and RMW paths.
- The FSM stays in mem_access_unit.

Test Plan:
- Preload word 0x10 = 0x8899AABB. LB addr 0x11 -> resp_rdata 0xFFFFFFAA; LBU 0x11 -> 0x000000AA; LH 0x12 -> 0xFFFF8899; LHU 0x12 -> 0x00008899; each resp_valid one cycle after accept.
- SB addr 0x13 data 0x55 over 0x8899AABB -> req_ready low one cycle, mem_we only in the RMW cycle, word becomes 0x5599AABB, resp_valid at N+2.
- SH addr 0x10 data 0x1234 -> word 0x8899_1234; immediately followed by LW 0x10 (held on req_valid) -> accepted at N+2, returns 0x88991234.
- LW 0x06, SH 0x03, and SW 0x1000 with MEM_WORDS=1024 -> each resp_err = 1, resp_rdata 0, mem_we never asserted.
- Four back-to-back LW to 0x0/0x4/0x8/0xC -> four consecutive resp_valid pulses with correct data, req_ready constantly 1.
- Assert reset in the RMW cycle of an SB -> no write (memory unchanged), no resp_valid, all outputs at reset values next cycle.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the MEM-stage data-memory initiator.
// Opcode bit 3 marks a store; bits 1:0 encode the access size.
package mem_access_pkg;

    typedef enum logic [3:0] {
        OP_LB  = 4'b0000,
        OP_LH  = 4'b0001,
        OP_LW  = 4'b0011,
        OP_LBU = 4'b0100,
        OP_LHU = 4'b0101,
        OP_SB  = 4'b1000,
        OP_SH  = 4'b1001,
        OP_SW  = 4'b1011
    } mem_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RMW  = 1'b1
    } state_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    function automatic logic is_store(input logic [3:0] op);
        return op[3];
    endfunction

    function automatic logic [1:0] access_size(input logic [3:0] op);
        case (op[1:0])
            2'b01:   return SIZE_H;
            2'b11:   return SIZE_W;
            default: return SIZE_B;
        endcase
    endfunction

    function automatic logic op_defined(input logic [3:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Little-endian lane handling: load extraction with sign/zero extension,
// and the merge of store data into an existing word for sub-word stores.
module lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        sign_ext,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel   = word[{lane, 3'b000} +: 8];
        half_sel   = lane[1] ? word[31:16] : word[15:0];
        load_data  = word;
        merge_data = word;
        case (size)
            SIZE_B: begin
                load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
                merge_data[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            SIZE_H: begin
                load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
                if (lane[1]) merge_data[31:16] = wdata[15:0];
                else         merge_data[15:0]  = wdata[15:0];
            end
            default: merge_data = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator: accepts load/store requests, returns a registered
// response, and stalls the pipeline for one cycle on sub-word stores (RMW).
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(MEM_WORDS * 4);

    state_e            state_q, state_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic [31:0]       merge_q, merge_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;

    logic              accept;
    logic              req_err;
    logic [1:0]        size;
    logic [ADDR_W-1:0] word_addr;
    logic [31:0]       lane_load;
    logic [31:0]       lane_merge;

    assign size      = access_size(req_op);
    assign word_addr = {req_addr[ADDR_W-1:2], 2'b00};
    assign req_err   = !op_defined(req_op)
                     || ({1'b0, req_addr} >= ADDR_LIMIT)
                     || (size == SIZE_H && req_addr[0])
                     || (size == SIZE_W && req_addr[1:0] != 2'b00);

    lane_align u_lane_align (
        .word       (mem_rdata),
        .wdata      (req_wdata),
        .size       (size),
        .lane       (req_addr[1:0]),
        .sign_ext   (!req_op[2]),
        .load_data  (lane_load),
        .merge_data (lane_merge)
    );

    // Handshake: a request transfers on a rising edge where req_valid && req_ready
    // are both high; resp_valid is a one-cycle pulse per transferred request.
    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        merge_d      = merge_q;
        waddr_d      = waddr_q;
        req_ready    = 1'b1;
        mem_we       = 1'b0;
        mem_addr     = word_addr;
        mem_wdata    = '0;
        accept       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                accept = req_valid && !reset;
                if (accept) begin
                    if (req_err) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (is_store(req_op)) begin
                        if (size == SIZE_W) begin
                            mem_we       = 1'b1;
                            mem_wdata    = req_wdata;
                            resp_valid_d = 1'b1;
                        end else begin
                            merge_d = lane_merge;
                            waddr_d = word_addr;
                            state_d = ST_RMW;
                        end
                    end else begin
                        resp_valid_d = 1'b1;
                        resp_rdata_d = lane_load;
                    end
                end
            end
            ST_RMW: begin
                req_ready    = 1'b0;
                mem_we       = 1'b1;
                mem_addr     = waddr_q;
                mem_wdata    = merge_q;
                resp_valid_d = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Reset suppresses any in-flight RMW write within the same cycle.
        if (reset) begin
            req_ready = 1'b1;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            merge_q      <= '0;
            waddr_q      <= '0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            merge_q      <= merge_d;
            waddr_q      <= waddr_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: word memory behind the port, a byte-level
// reference model, directed vectors, corner sequences and random traffic.
module tb_mem_access_unit;

    localparam logic [3:0] LB  = 4'b0000;
    localparam logic [3:0] LH  = 4'b0001;
    localparam logic [3:0] LW  = 4'b0011;
    localparam logic [3:0] LBU = 4'b0100;
    localparam logic [3:0] LHU = 4'b0101;
    localparam logic [3:0] SB  = 4'b1000;
    localparam logic [3:0] SH  = 4'b1001;
    localparam logic [3:0] SW  = 4'b1011;
    localparam logic [3:0] BAD = 4'b0010;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem     [0:1023] = '{default: '0};
    logic [31:0] ref_mem [0:1023] = '{default: '0};
    logic [31:0] exp_q[$];

    int total = 0;
    int bad   = 0;

    mem_access_unit #(.MEM_WORDS(1024), .ADDR_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Clock / reset support and the memory behind the port
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[11:2]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
    end

    always @(negedge clk) begin
        if (mem_we) begin
            total++;
            if (mem_addr >= 32'd4096 || mem_addr[1:0] != 2'b00) begin
                bad++;
                $display("FAIL write_addr: mem_addr=%h is not a legal word address", mem_addr);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: byte-addressed semantics from the opcode rules
    function automatic void model(input logic [3:0] op, input logic [31:0] addr,
                                  input logic [31:0] wdata, output logic [31:0] rd,
                                  output logic err, output int lat);
        int          nbytes;
        logic        known;
        int          sh;
        logic [31:0] low, word, v;
        known  = 1'b1;
        nbytes = 1;
        case (op)
            LB, LBU, SB: nbytes = 1;
            LH, LHU, SH: nbytes = 2;
            LW, SW:      nbytes = 4;
            default:     known = 1'b0;
        endcase
        err = !known || addr >= 32'd4096 || (addr % nbytes) != 0;
        rd  = '0;
        lat = 1;
        if (err) return;
        sh   = int'(addr % 4) * 8;
        low  = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
        word = ref_mem[addr / 4];
        if (op[3]) begin
            ref_mem[addr / 4] = (word & ~(low << sh)) | ((wdata & low) << sh);
            lat = (nbytes == 4) ? 1 : 2;
        end else begin
            v = (word >> sh) & low;
            if ((op == LB || op == LH) && v[8 * nbytes - 1]) v = v | ~low;
            rd = v;
        end
    endfunction

    // Driver: one request, then check accept, write enables, latency and response.
    // Entered and left just after a rising edge.
    task automatic run_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                           input string name);
        int          wait_c;
        int          lat;
        logic [31:0] e;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        exp_q.push_back(exp_rdata);
        wait_c = 0;
        @(negedge clk);
        while (!req_ready && wait_c < 8) begin
            @(negedge clk);
            wait_c++;
        end
        chk({name, " ready"}, {31'd0, req_ready}, 32'd1);
        chk({name, " we_accept"}, {31'd0, mem_we}, {31'd0, (op == SW && !exp_err)});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!resp_valid && lat < 4) begin
            if (lat == 1 && exp_lat == 2) begin
                chk({name, " rmw_ready"}, {31'd0, req_ready}, 32'd0);
                chk({name, " rmw_we"}, {31'd0, mem_we}, 32'd1);
            end
            @(negedge clk);
            lat++;
        end
        e = exp_q.pop_front();
        chk({name, " resp_valid"}, {31'd0, resp_valid}, 32'd1);
        chk({name, " latency"}, lat, exp_lat);
        chk({name, " rdata"}, resp_rdata, e);
        chk({name, " err"}, {31'd0, resp_err}, {31'd0, exp_err});
        chk({name, " we_idle"}, {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        chk({name, " single_pulse"}, {31'd0, resp_valid}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_model(input logic [3:0] op, input logic [31:0] addr,
                             input logic [31:0] wdata, input string name);
        logic [31:0] rd;
        logic        err;
        int          lat;
        model(op, addr, wdata, rd, err, lat);
        run_req(op, addr, wdata, rd, err, lat, name);
        if (addr < 32'd4096) chk({name, " mem_word"}, mem[addr[11:2]], ref_mem[addr[11:2]]);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vt [19];

    initial begin
        logic [31:0] rd;
        logic        err;
        int          lat;
        logic [3:0]  ops [10];
        logic [31:0] b2b_exp [4];

        vt[0]  = '{LB,  32'h11, 32'h0,  32'hFFFF_FFAA, 1'b0, 1};
        vt[1]  = '{LBU, 32'h11, 32'h0,  32'h0000_00AA, 1'b0, 1};
        vt[2]  = '{LH,  32'h12, 32'h0,  32'hFFFF_8899, 1'b0, 1};
        vt[3]  = '{LHU, 32'h12, 32'h0,  32'h0000_8899, 1'b0, 1};
        vt[4]  = '{LB,  32'h10, 32'h0,  32'hFFFF_FFBB, 1'b0, 1};
        vt[5]  = '{LBU, 32'h13, 32'h0,  32'h0000_0088, 1'b0, 1};
        vt[6]  = '{SB,  32'h13, 32'h55, 32'h0,         1'b0, 2};
        vt[7]  = '{LW,  32'h10, 32'h0,  32'h5599_AABB, 1'b0, 1};
        vt[8]  = '{LW,  32'h06, 32'h0,  32'h0,         1'b1, 1};
        vt[9]  = '{SH,  32'h03, 32'hFFFF, 32'h0,       1'b1, 1};
        vt[10] = '{SW,  32'h1000, 32'h1, 32'h0,        1'b1, 1};
        vt[11] = '{BAD, 32'h0,  32'h0,  32'h0,         1'b1, 1};
        vt[12] = '{LH,  32'h11, 32'h0,  32'h0,         1'b1, 1};
        vt[13] = '{SW,  32'h20, 32'hDEAD_BEEF, 32'h0,  1'b0, 1};
        vt[14] = '{LW,  32'h20, 32'h0,  32'hDEAD_BEEF, 1'b0, 1};
        vt[15] = '{SH,  32'h22, 32'hCAFE, 32'h0,       1'b0, 2};
        vt[16] = '{LW,  32'h20, 32'h0,  32'hCAFE_BEEF, 1'b0, 1};
        vt[17] = '{LH,  32'h20, 32'h0,  32'hFFFF_BEEF, 1'b0, 1};
        vt[18] = '{LBU, 32'h23, 32'h0,  32'h0000_00CA, 1'b0, 1};

        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 4'h0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst resp_rdata", resp_rdata, 32'd0);
        chk("rst resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst mem_wdata", mem_wdata, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_model(SW, 32'h0,  32'h0102_0304, "pre0");
        run_model(SW, 32'h4,  32'hA5A5_5A5A, "pre4");
        run_model(SW, 32'h8,  32'h8000_0001, "pre8");
        run_model(SW, 32'hC,  32'h7FFF_FFFE, "preC");
        run_model(SW, 32'h10, 32'h8899_AABB, "pre10");

        for (int i = 0; i < 19; i++) begin
            model(vt[i].op, vt[i].addr, vt[i].wdata, rd, err, lat);
            run_req(vt[i].op, vt[i].addr, vt[i].wdata, vt[i].exp_rdata, vt[i].exp_err,
                    vt[i].exp_lat, $sformatf("vec%0d", i));
            if (vt[i].addr < 32'd4096)
                chk($sformatf("vec%0d mem_word", i), mem[vt[i].addr[11:2]], ref_mem[vt[i].addr[11:2]]);
        end

        // Four back-to-back word loads at full rate
        for (int i = 0; i < 4; i++) b2b_exp[i] = ref_mem[i];
        req_valid = 1'b1;
        req_op    = LW;
        req_addr  = 32'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("b2b%0d ready", i), {31'd0, req_ready}, 32'd1);
            if (i > 0) begin
                chk($sformatf("b2b%0d valid", i), {31'd0, resp_valid}, 32'd1);
                chk($sformatf("b2b%0d rdata", i), resp_rdata, b2b_exp[i-1]);
            end
            @(posedge clk);
            #1;
            if (i < 3) req_addr = 32'(4 * (i + 1));
            else       req_valid = 1'b0;
        end
        @(negedge clk);
        chk("b2b tail_valid", {31'd0, resp_valid}, 32'd0);
        @(posedge clk);
        #1;

        // SH followed by a load held on req_valid through the RMW cycle
        run_model(SW, 32'h10, 32'h8899_AABB, "pre10b");
        req_valid = 1'b1;
        req_op    = SH;
        req_addr  = 32'h10;
        req_wdata = 32'h0000_1234;
        @(negedge clk);
        chk("held acc_ready", {31'd0, req_ready}, 32'd1);
        chk("held acc_we", {31'd0, mem_we}, 32'd0);
        @(posedge clk);
        #1;
        req_op    = LW;
        req_addr  = 32'h10;
        req_wdata = 32'h0;
        @(negedge clk);
        chk("held rmw_ready", {31'd0, req_ready}, 32'd0);
        chk("held rmw_we", {31'd0, mem_we}, 32'd1);
        chk("held rmw_wdata", mem_wdata, 32'h8899_1234);
        chk("held rmw_addr", mem_addr, 32'h10);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("held sh_valid", {31'd0, resp_valid}, 32'd1);
        chk("held sh_rdata", resp_rdata, 32'd0);
        chk("held ld_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("held lw_valid", {31'd0, resp_valid}, 32'd1);
        chk("held lw_rdata", resp_rdata, 32'h8899_1234);
        ref_mem[4] = 32'h8899_1234;
        @(posedge clk);
        #1;

        // Reset asserted during the RMW cycle of an SB
        run_model(SW, 32'h10, 32'h8899_AABB, "pre10c");
        req_valid = 1'b1;
        req_op    = SB;
        req_addr  = 32'h13;
        req_wdata = 32'h55;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 32'h0;
        reset     = 1'b1;
        @(negedge clk);
        chk("rstrmw we", {31'd0, mem_we}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rstrmw resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rstrmw req_ready", {31'd0, req_ready}, 32'd1);
        chk("rstrmw resp_rdata", resp_rdata, 32'd0);
        chk("rstrmw resp_err", {31'd0, resp_err}, 32'd0);
        chk("rstrmw mem_we", {31'd0, mem_we}, 32'd0);
        chk("rstrmw mem_addr", mem_addr, 32'd0);
        chk("rstrmw mem_wdata", mem_wdata, 32'd0);
        chk("rstrmw mem_word", mem[4], 32'h8899_AABB);
        @(negedge clk);
        chk("rstrmw late_valid", {31'd0, resp_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Random traffic against the reference model
        ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW, BAD, 4'b1111};
        for (int i = 0; i < 150; i++) begin
            logic [3:0]  op;
            logic [31:0] addr;
            op   = ops[$urandom_range(0, 9)];
            addr = ($urandom_range(0, 15) == 0) ? 32'h1000 + 32'($urandom_range(0, 63))
                                                : 32'($urandom_range(0, 127));
            run_model(op, addr, $urandom, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
